// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation codes and
// the controller state encoding.
package shift_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SAR = 3'b100;
    localparam logic [2:0] OP_RCL = 3'b101;
    localparam logic [2:0] OP_RCR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One 1-bit step of every supported shift/rotate operation. Purely
// combinational; the top block iterates it once per clock.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic             cin,
    output logic [WIDTH-1:0] data_nxt,
    output logic             cout
);

    always_comb begin
        data_nxt = data;
        cout     = cin;
        case (op)
            OP_ROL: begin
                data_nxt = {data[WIDTH-2:0], data[WIDTH-1]};
                cout     = data[WIDTH-1];
            end
            OP_ROR: begin
                data_nxt = {data[0], data[WIDTH-1:1]};
                cout     = data[0];
            end
            OP_SHL: begin
                data_nxt = {data[WIDTH-2:0], 1'b0};
                cout     = data[WIDTH-1];
            end
            OP_SHR: begin
                data_nxt = {1'b0, data[WIDTH-1:1]};
                cout     = data[0];
            end
            OP_SAR: begin
                data_nxt = {data[WIDTH-1], data[WIDTH-1:1]};
                cout     = data[0];
            end
            // Carry acts as bit WIDTH of a WIDTH+1-bit ring.
            OP_RCL: begin
                data_nxt = {data[WIDTH-2:0], cin};
                cout     = data[WIDTH-1];
            end
            OP_RCR: begin
                data_nxt = {cin, data[WIDTH-1:1]};
                cout     = data[0];
            end
            default: begin
                data_nxt = data;
                cout     = cin;
            end
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate engine: one bit position per clock through a single
// shift_step, with start/done handshake and carry/zero/illegal flags.
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amt,
    input  logic             carry_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_out,
    output logic             illegal_op
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             wc_q, wc_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] step_data;
    logic             step_cout;
    logic             load_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_q),
        .data     (work_q),
        .cin      (wc_q),
        .data_nxt (step_data),
        .cout     (step_cout)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        wc_d    = wc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = operand;
                    wc_d    = carry_in;
                    op_d    = op;
                    cnt_d   = amt;
                    state_d = (amt != '0 && op != OP_ILL) ? SHIFT : DONE;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = step_data;
                wc_d   = step_cout;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DONE without start always leaves to IDLE, so a DONE next state always
    // marks a freshly completed operation whose work values become visible.
    always_comb begin
        load_out = (state_d == DONE);
        result_d = load_out ? work_d             : result_q;
        carry_d  = load_out ? wc_d               : carry_q;
        zero_d   = load_out ? (work_d == '0)     : zero_q;
        ill_d    = load_out ? (op_d == OP_ILL)   : ill_q;
        done_d   = (state_d == DONE);
        busy_d   = (state_d == SHIFT);
        ready_d  = (state_d != SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            wc_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            wc_q     <= wc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign carry_out  = carry_q;
    assign zero_out   = zero_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench for shift_rotate_unit (WIDTH=8): expectations from a
// closed-form model are queued at issue and checked when done pulses.
module tb_shift_rotate_unit;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  operand = '0;
    logic [AW-1:0] amt = '0;
    logic          carry_in = 1'b0;
    logic          ready, busy, done, carry_out, zero_out, illegal_op;
    logic [W-1:0]  result;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         ill;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] prev_res = '0;
    logic         prev_c = 1'b0;

    shift_rotate_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .operand    (operand),
        .amt        (amt),
        .carry_in   (carry_in),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .zero_out   (zero_out),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] d,
                                   input logic [AW-1:0] k, input logic ci, input int c0);
        exp_t         e;
        int           kk;
        logic [W:0]   v, w;
        logic signed [W-1:0] sd;
        kk    = int'(k);
        e.res = d;
        e.c   = ci;
        e.ill = (o == 3'b111);
        e.cyc = c0 + ((o == 3'b111) ? 0 : kk);
        if (kk != 0 && o != 3'b111) begin
            case (o)
                3'b000: begin e.res = W'((d << kk) | (d >> (W - kk))); e.c = e.res[0]; end
                3'b001: begin e.res = W'((d >> kk) | (d << (W - kk))); e.c = e.res[W-1]; end
                3'b010: begin e.res = W'(d << kk); e.c = d[W-kk]; end
                3'b011: begin e.res = d >> kk; e.c = d[kk-1]; end
                3'b100: begin sd = d; e.res = sd >>> kk; e.c = d[kk-1]; end
                3'b101: begin
                    v = {ci, d};
                    w = (W+1)'((v << kk) | (v >> (W + 1 - kk)));
                    e.res = w[W-1:0]; e.c = w[W];
                end
                default: begin
                    v = {d, ci};
                    w = (W+1)'((v >> kk) | (v << (W + 1 - kk)));
                    e.res = w[W:1]; e.c = w[0];
                end
            endcase
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    // Issue one op as soon as the unit is ready; expectation is queued now.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] d,
                          input logic [AW-1:0] k, input logic ci);
        int t = 0;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            check("ready_timeout", {31'd0, ready}, 32'd1);
            return;
        end
        op = o; operand = d; amt = k; carry_in = ci; start = 1'b1;
        sb.push_back(model(o, d, k, ci, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("carry_out", carry_out, e.c);
                    check("zero_out", zero_out, e.z);
                    check("illegal_op", illegal_op, e.ill);
                    check("latency", cyc, e.cyc);
                    prev_res = e.res;
                    prev_c   = e.c;
                end
            end else if (busy) begin
                check("hold_result", result, prev_res);
                check("hold_carry", carry_out, prev_c);
                check("ready_in_shift", ready, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_result", result, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {carry_out, zero_out, illegal_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b000, 8'h96, 3'd1, 1'b0);  // ROL
        drain();
        run_op(3'b001, 8'h01, 3'd3, 1'b0);  // ROR, result held while busy
        drain();
        run_op(3'b100, 8'h80, 3'd7, 1'b0);  // SAR
        run_op(3'b011, 8'h80, 3'd7, 1'b0);  // SHR
        run_op(3'b101, 8'h80, 3'd1, 1'b0);  // RCL -> zero
        run_op(3'b110, 8'h81, 3'd2, 1'b1);  // RCR
        run_op(3'b010, 8'hC1, 3'd2, 1'b0);  // SHL
        drain();
        run_op(3'b011, 8'h5A, 3'd0, 1'b1);  // amt=0 passthrough
        run_op(3'b111, 8'h5A, 3'd4, 1'b1);  // illegal, back-to-back from DONE
        run_op(3'b000, 8'h3C, 3'd0, 1'b0);
        drain();

        // start pulsed while shifting must be ignored
        run_op(3'b001, 8'h01, 3'd3, 1'b0);
        @(negedge clk);
        op = 3'b010; operand = 8'hFF; amt = 3'd1; carry_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();

        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)),
                   1'($urandom));
        end
        drain();

        // asynchronous reset in the middle of a 5-step ROL
        run_op(3'b000, 8'hC3, 3'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_flags", {carry_out, zero_out, illegal_op}, 0);
        sb.delete();
        prev_res = '0;
        prev_c   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_idle", {ready, busy}, 2'b10);
        end

        run_op(3'b000, 8'h96, 3'd5, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
